// File: rtl/kbd_fifo.sv
// kbd_fifo: PS/2 scancode FIFO with an optional make/break/extended prefix decoder and a
// two-register CPU read port.
//
// Ports
//   clk      system clock, all state changes on the rising edge
//   rst      asynchronous active-high reset
//   sc_stb   one-cycle strobe: sc_data holds a new scancode byte
//   sc_data  scancode byte
//   cs_n     active-low chip select
//   r_n      active-low read strobe
//   addr     register select: 0 = data (head code), 1 = status
//   data     CPU data bus, driven only while cs_n=0 and r_n=0
//   irq      registered level interrupt, high while the FIFO holds entries
//
// Status register: bit0 not-empty, bit1 overflow (sticky), bit2 full,
// bit6 head extended, bit7 head break.
//
// Build option: define KBD_FIFO_PREFIX_DECODE_EN to fold the E0/F0 prefix bytes into the
// EXT/BRK flags of the following code. Without it every byte is queued verbatim.

module kbd_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sc_stb,
   input  logic [7:0] sc_data,
   input  logic       cs_n,
   input  logic       r_n,
   input  logic       addr,
   inout  wire  [7:0] data,
   output logic       irq
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic          push;
   logic          push_ext;
   logic          push_brk;

`ifdef KBD_FIFO_PREFIX_DECODE_EN
   localparam logic [7:0] PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PREFIX_BRK = 8'hF0;

   typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} dec_state_e;

   dec_state_e state_q, state_d;
   logic       is_e0, is_f0;

   assign is_e0 = (sc_data == PREFIX_EXT);
   assign is_f0 = (sc_data == PREFIX_BRK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Repeated prefixes are ignored and hold the state; anything else ends the sequence.
   always_comb begin
      state_d = state_q;
      if (sc_stb) begin
         unique case (state_q)
            StIdle: begin
               if (is_e0)      state_d = StExt;
               else if (is_f0) state_d = StBrk;
            end
            StBrk: begin
               if (!is_f0) state_d = StIdle;
            end
            StExt: begin
               if (is_f0)       state_d = StExtBrk;
               else if (!is_e0) state_d = StIdle;
            end
            StExtBrk: begin
               if (!is_e0 && !is_f0) state_d = StIdle;
            end
         endcase
      end
   end

   // In BRK an E0 is not a legal prefix, so it is queued as an ordinary break code.
   always_comb begin
      push     = 1'b0;
      push_ext = 1'b0;
      push_brk = 1'b0;
      if (sc_stb) begin
         unique case (state_q)
            StIdle:   push = !is_e0 && !is_f0;
            StBrk: begin
               push     = !is_f0;
               push_brk = 1'b1;
            end
            StExt: begin
               push     = !is_e0 && !is_f0;
               push_ext = 1'b1;
            end
            StExtBrk: begin
               push     = !is_e0 && !is_f0;
               push_ext = 1'b1;
               push_brk = 1'b1;
            end
         endcase
      end
   end
`else
   assign push     = sc_stb;
   assign push_ext = 1'b0;
   assign push_brk = 1'b0;
`endif

   // FIFO state
   logic [9:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          irq_q;
   logic          rd_act_q, addr_q;

   logic          rd_act, rd_end;
   logic          pop, push_ok, ovf_clr, overflow;
   logic          full, not_empty;
   logic [9:0]    head;
   logic [7:0]    rd_val;

   assign rd_act    = !cs_n && !r_n;
   // A bus read takes effect once, on the first edge after the strobe is released.
   assign rd_end    = rd_act_q && !rd_act;
   assign not_empty = (count_q != '0);
   assign full      = (count_q == CW'(DEPTH));
   assign pop       = rd_end && !addr_q && not_empty;
   assign ovf_clr   = rd_end && addr_q;
   // A simultaneous pop frees the slot, so a push into a full FIFO still fits.
   assign push_ok   = push && (!full || pop);
   assign overflow  = push && full && !pop;

   always_comb begin
      count_d = count_q + CW'(push_ok) - CW'(pop);
      ovf_d   = ovf_q;
      if (ovf_clr)  ovf_d = 1'b0;
      if (overflow) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         irq_q    <= 1'b0;
         rd_act_q <= 1'b0;
         addr_q   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         irq_q    <= not_empty;
         rd_act_q <= rd_act;
         addr_q   <= addr;
      end
   end

   // Storage is not reset; empty reads are masked below.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= {push_ext, push_brk, sc_data};
   end

   assign head = mem_q[rd_ptr_q];

   always_comb begin
      rd_val = 8'h00;
      if (addr) begin
         rd_val = {not_empty & head[8], not_empty & head[9], 3'b000, full, ovf_q, not_empty};
      end else if (not_empty) begin
         rd_val = head[7:0];
      end
   end

   assign data = rd_act ? rd_val : 8'hzz;
   assign irq  = irq_q;

endmodule

// File: tb/tb_kbd_fifo.sv
// tb_kbd_fifo: directed and randomized checks of kbd_fifo against a queue-based model.
// Honours KBD_FIFO_PREFIX_DECODE_EN the same way the design does.

module tb_kbd_fifo;

   localparam int unsigned DEPTH = 8;
`ifdef KBD_FIFO_PREFIX_DECODE_EN
   localparam bit DEC = 1'b1;
`else
   localparam bit DEC = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sc_stb = 1'b0;
   logic [7:0] sc_data = 8'h00;
   logic       cs_n = 1'b1;
   logic       r_n = 1'b1;
   logic       addr = 1'b0;
   wire  [7:0] data;
   logic       irq;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   kbd_fifo #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .sc_stb  (sc_stb),
      .sc_data (sc_data),
      .cs_n    (cs_n),
      .r_n     (r_n),
      .addr    (addr),
      .data    (data),
      .irq     (irq)
   );

   // Reference model: queue of {ext, brk, code}, plus pending-prefix flags.
   logic [9:0] q[$];
   bit m_ovf, m_ext, m_brk, m_rd_prev, m_addr_prev, m_irq;

   function automatic logic [7:0] exp_bus(input logic a);
      logic [9:0] h;
      bit ne;
      ne = (q.size() != 0);
      h  = ne ? q[0] : 10'h000;
      if (a) return {h[8], h[9], 3'b000, (q.size() == DEPTH), m_ovf, ne};
      return h[7:0];
   endfunction

   // Advance one clock, updating the model from the inputs currently driven.
   task automatic step();
      bit push, rd_now, rd_end, irq_n;
      logic [9:0] ent;
      push = 1'b0;
      ent  = 10'h000;
      if (sc_stb) begin
         if (DEC) begin
            if (sc_data == 8'hE0 && !m_ext && !m_brk) m_ext = 1'b1;
            else if (sc_data == 8'hE0 && m_ext) ;
            else if (sc_data == 8'hF0) m_brk = 1'b1;
            else begin
               push  = 1'b1;
               ent   = {m_ext, m_brk, sc_data};
               m_ext = 1'b0;
               m_brk = 1'b0;
            end
         end else begin
            push = 1'b1;
            ent  = {2'b00, sc_data};
         end
      end
      rd_now = !cs_n && !r_n;
      rd_end = m_rd_prev && !rd_now;
      irq_n  = (q.size() != 0);
      if (rd_end && m_addr_prev) m_ovf = 1'b0;
      if (rd_end && !m_addr_prev && q.size() > 0) void'(q.pop_front());
      if (push) begin
         if (q.size() < DEPTH) q.push_back(ent);
         else m_ovf = 1'b1;
      end
      m_rd_prev   = rd_now;
      m_addr_prev = addr;
      m_irq       = irq_n;
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      sc_stb  = 1'b1;
      sc_data = b;
      step();
      sc_stb  = 1'b0;
   endtask

   // Bus read: value sampled as the strobe starts, held len cycles, then released.
   task automatic read_bus(input logic a, input int len, output logic [7:0] v);
      cs_n = 1'b0;
      r_n  = 1'b0;
      addr = a;
      #1;
      v = data;
      repeat (len) step();
      cs_n = 1'b1;
      r_n  = 1'b1;
      step();
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      sc_stb = 1'b0;
      cs_n   = 1'b1;
      r_n    = 1'b1;
      addr   = 1'b0;
      q.delete();
      m_ovf = 0; m_ext = 0; m_brk = 0; m_rd_prev = 0; m_addr_prev = 0; m_irq = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      do_reset();
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq: got %b expected 0", irq);
      end
      read_bus(1'b1, 1, v);
      checks++;
      if (v !== 8'h00) begin
         errors++;
         $display("FAIL reset_status: got %h expected 00", v);
      end
      read_bus(1'b0, 1, v);
      checks++;
      if (v !== 8'h00) begin
         errors++;
         $display("FAIL reset_data: got %h expected 00", v);
      end
   endtask

   task automatic test_basic();
      logic [7:0] v;
      push_byte(8'h1C);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL basic_irq_latency: got %b expected 0", irq);
      end
      step();
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL basic_irq_set: got %b expected 1", irq);
      end
      read_bus(1'b1, 1, v);
      checks++;
      if (v !== 8'h01) begin
         errors++;
         $display("FAIL basic_status: got %h expected 01", v);
      end
      read_bus(1'b0, 1, v);
      checks++;
      if (v !== 8'h1C) begin
         errors++;
         $display("FAIL basic_data: got %h expected 1c", v);
      end
      step();
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL basic_irq_clear: got %b expected 0", irq);
      end
   endtask

   task automatic test_prefix();
      logic [7:0] v;
      logic [7:0] es[5];
      logic [7:0] ed[5];
      int n;
      push_byte(8'hF0);
      push_byte(8'h1C);
      push_byte(8'hE0);
      push_byte(8'hF0);
      push_byte(8'h75);
      if (DEC) begin
         n = 2;
         es[0] = 8'h81; ed[0] = 8'h1C;
         es[1] = 8'hC1; ed[1] = 8'h75;
      end else begin
         n = 5;
         for (int i = 0; i < 5; i++) es[i] = 8'h01;
         ed[0] = 8'hF0; ed[1] = 8'h1C; ed[2] = 8'hE0; ed[3] = 8'hF0; ed[4] = 8'h75;
      end
      for (int i = 0; i < n; i++) begin
         read_bus(1'b1, 1, v);
         checks++;
         if (v !== es[i]) begin
            errors++;
            $display("FAIL prefix_status[%0d]: got %h expected %h", i, v, es[i]);
         end
         read_bus(1'b0, 1, v);
         checks++;
         if (v !== ed[i]) begin
            errors++;
            $display("FAIL prefix_data[%0d]: got %h expected %h", i, v, ed[i]);
         end
      end
      read_bus(1'b1, 1, v);
      checks++;
      if (v !== 8'h00) begin
         errors++;
         $display("FAIL prefix_empty: got %h expected 00", v);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] v;
      for (int i = 1; i <= 9; i++) push_byte(8'(i));
      read_bus(1'b1, 1, v);
      checks++;
      if (v !== 8'h07) begin
         errors++;
         $display("FAIL ovf_status: got %h expected 07", v);
      end
      read_bus(1'b1, 1, v);
      checks++;
      if (v !== 8'h05) begin
         errors++;
         $display("FAIL ovf_cleared: got %h expected 05", v);
      end
      for (int i = 1; i <= 8; i++) begin
         read_bus(1'b0, 1, v);
         checks++;
         if (v !== 8'(i)) begin
            errors++;
            $display("FAIL ovf_data[%0d]: got %h expected %h", i, v, 8'(i));
         end
      end
      read_bus(1'b1, 1, v);
      checks++;
      if (v !== 8'h00) begin
         errors++;
         $display("FAIL ovf_drained: got %h expected 00", v);
      end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] v;
      logic [7:0] e;
      for (int i = 0; i < 8; i++) push_byte(8'hA0 + 8'(i));
      cs_n = 1'b0;
      r_n  = 1'b0;
      addr = 1'b0;
      step();
      // Strobe release and the new byte land on the same edge.
      cs_n    = 1'b1;
      r_n     = 1'b1;
      sc_stb  = 1'b1;
      sc_data = 8'hB5;
      step();
      sc_stb = 1'b0;
      read_bus(1'b1, 1, v);
      checks++;
      if (v !== 8'h05) begin
         errors++;
         $display("FAIL fullpp_status: got %h expected 05", v);
      end
      for (int i = 0; i < 8; i++) begin
         e = (i == 7) ? 8'hB5 : 8'hA1 + 8'(i);
         read_bus(1'b0, 1, v);
         checks++;
         if (v !== e) begin
            errors++;
            $display("FAIL fullpp_data[%0d]: got %h expected %h", i, v, e);
         end
      end
   endtask

   task automatic test_reset_prefix();
      logic [7:0] v;
      push_byte(8'hE0);
      do_reset();
      push_byte(8'h1C);
      read_bus(1'b1, 1, v);
      checks++;
      if (v !== 8'h01) begin
         errors++;
         $display("FAIL rstpfx_status: got %h expected 01", v);
      end
      read_bus(1'b0, 1, v);
      checks++;
      if (v !== 8'h1C) begin
         errors++;
         $display("FAIL rstpfx_data: got %h expected 1c", v);
      end
   endtask

   task automatic test_long_strobe();
      logic [7:0] v;
      push_byte(8'h33);
      push_byte(8'h44);
      read_bus(1'b0, 10, v);
      checks++;
      if (v !== 8'h33) begin
         errors++;
         $display("FAIL long_data: got %h expected 33", v);
      end
      read_bus(1'b1, 1, v);
      checks++;
      if (v !== 8'h01) begin
         errors++;
         $display("FAIL long_one_pop: got %h expected 01", v);
      end
      read_bus(1'b0, 1, v);
      checks++;
      if (v !== 8'h44) begin
         errors++;
         $display("FAIL long_second: got %h expected 44", v);
      end
      read_bus(1'b0, 3, v);
      checks++;
      if (v !== 8'h00) begin
         errors++;
         $display("FAIL empty_data: got %h expected 00", v);
      end
      read_bus(1'b1, 1, v);
      checks++;
      if (v !== 8'h00) begin
         errors++;
         $display("FAIL empty_status: got %h expected 00", v);
      end
   endtask

   task automatic test_random();
      bit reading;
      int rd_left;
      int r;
      logic [7:0] e;
      reading = 1'b0;
      rd_left = 0;
      for (int i = 0; i < 800; i++) begin
         if (reading) begin
            if (rd_left > 0) rd_left--;
            else begin
               reading = 1'b0;
               cs_n    = 1'b1;
               r_n     = 1'b1;
            end
         end else if ($urandom % 5 == 0) begin
            reading = 1'b1;
            addr    = 1'($urandom % 2);
            cs_n    = 1'b0;
            r_n     = 1'b0;
            rd_left = $urandom_range(0, 2);
         end else if ($urandom % 7 == 0) begin
            cs_n = 1'b0;
            r_n  = 1'b1;
         end else begin
            cs_n = 1'b1;
            r_n  = 1'b1;
         end
         sc_stb = 1'($urandom % 2);
         r = $urandom % 6;
         case (r)
            0:       sc_data = 8'hE0;
            1:       sc_data = 8'hF0;
            2:       sc_data = 8'hE1;
            default: sc_data = 8'($urandom);
         endcase
         #1;
         if (!cs_n && !r_n) begin
            e = exp_bus(addr);
            checks++;
            if (data !== e) begin
               errors++;
               $display("FAIL rand_bus[%0d] addr=%0d: got %h expected %h", i, addr, data, e);
            end
         end
         checks++;
         if (irq !== m_irq) begin
            errors++;
            $display("FAIL rand_irq[%0d]: got %b expected %b", i, irq, m_irq);
         end
         step();
      end
      sc_stb = 1'b0;
      cs_n   = 1'b1;
      r_n    = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_prefix();
      test_overflow();
      test_full_push_pop();
      test_reset_prefix();
      test_long_strobe();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/kbd_fifo.md
KBD_FIFO -- requirements
Module: kbd_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, minimum 2.
REQ-002 CLK  in  1  system clock; all state changes on rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 SC_STB  in  1  one-CLK pulse, synchronous to CLK: new scancode byte from the PS/2 receiver stage.
REQ-005 SC_DATA  in  8  scancode byte; valid while SC_STB=1.
REQ-006 CS_N  in  1  active-low chip select from the CPU bus decoder.
REQ-007 R_N  in  1  active-low read strobe.
REQ-008 ADDR  in  1  register select: 0 = data, 1 = status.
REQ-009 DATA  inout  8  CPU data bus; driven only when CS_N=0 and R_N=0, else high-Z.
REQ-010 IRQ  out  1  level interrupt request, active-high.

Function
REQ-011 Each entry is 10 bits: {EXT, BRK, CODE[7:0]}.
REQ-012 Prefix decoder states: IDLE, BRK (after F0), EXT (after E0), EXTBRK (E0 then F0).
REQ-013 Transitions on SC_STB: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXTBRK; any other byte pushes {ext, brk, byte} and returns to IDLE.
REQ-014 Prefix bytes (E0, F0) are never pushed; E0 received in EXT or EXTBRK, or F0 received in BRK or EXTBRK, is ignored and the state is held.
REQ-015 E1 and all other codes are pushed as ordinary bytes.
REQ-016 Push latency: the entry is visible at the FIFO head on the CLK edge that samples SC_STB=1 with a non-prefix byte.
REQ-017 ADDR=0 read returns the head CODE, or 0x00 when empty.
REQ-018 ADDR=1 read returns status: bit0 NOT_EMPTY, bit1 OVF, bit2 FULL, bits5:3 0, bit6 head EXT, bit7 head BRK (bits 7:6 are 0 when empty).
REQ-019 Bus read active = CS_N=0 and R_N=0, registered once per CLK.
REQ-020 Pop occurs on the first CLK edge where the registered read-active is 1, the current read-active is 0, and the registered ADDR is 0; exactly one pop per bus read regardless of strobe length.
REQ-021 A pop when empty has no effect.
REQ-022 The end of a status read (same edge rule, registered ADDR=1) clears OVF.
REQ-023 A push when full and no simultaneous pop drops the entry and sets sticky OVF.
REQ-024 A push and a pop on the same edge both succeed, including when full; count is unchanged and OVF is not set.
REQ-025 A push on the same edge as an OVF clear leaves OVF=1 if that push overflows.
REQ-026 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-027 IRQ is registered; it is 1 on the cycle after count becomes non-zero and 0 on the cycle after count reaches 0.
REQ-028 DATA output is combinational from head/status, with no extra latency on reads.

Reset
REQ-029 RST=1 asynchronously clears pointers, count, OVF, IRQ, registered bus samples, and forces the decoder to IDLE.
REQ-030 Reset mid-prefix (e.g. after E0) discards the prefix; the next byte is decoded from IDLE.
REQ-031 FIFO storage need not be cleared; DATA reads 0x00 after reset because the FIFO is empty.

Configuration
REQ-032 Macro KBD_FIFO_PREFIX_DECODE_EN.
REQ-033 When defined: prefix decoding per REQ-012..015.
REQ-034 When undefined: no decoder state; every SC_STB byte, including E0 and F0, is pushed with EXT=0 and BRK=0.

Verification
REQ-035 Reset, then push 1C -> IRQ=1 one cycle later; status read=0x01; data read=0x1C; IRQ=0 after the read ends.
REQ-036 Push F0,1C then E0,F0,75 -> two entries: status 0x81 with data 1C, then status 0xC1 with data 75 (macro defined); same stimulus with macro undefined -> five entries F0,1C,E0,F0,75.
REQ-037 Push 9 bytes 01..09 with DEPTH=8 -> status 0x07; reads return 01..08; 09 lost; OVF cleared after the status read ends.
REQ-038 FIFO full, push and data read complete on the same edge -> count stays 8, OVF=0, new byte appears last.
REQ-039 Push E0, assert RST, release, push 1C -> entry {0,0,1C} (status 0x01).
REQ-040 Data read strobe held low 10 CLK -> exactly one pop; read when empty -> 0x00 and count stays 0.
